// File: rtl/mdu_core_if.sv
// mdu_core_if: E-stage <-> multiply/divide unit bus.
// Ports (signals):
//   start, op[3:0], a, b, flush : issued by the pipeline (master)
//   busy, hi, lo                : returned by the MDU (slave)
interface mdu_core_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, hi, lo);
endinterface

// File: rtl/mdu_core.sv
// mdu_core: multi-cycle multiply/divide/accumulate unit owning HI/LO.
// Ports:
//   clk   : clock, all state changes on rising edge
//   reset : synchronous active-high, clears all state
//   mdu   : slave side of mdu_core_if (start/op/a/b/flush in, busy/hi/lo out)
module mdu_core #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_core_if.slave  mdu
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int unsigned DW         = 2 * WIDTH;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] a_q, a_nx, b_q, b_nx;
  logic [3:0]       op_q, op_nx;
  logic [DW-1:0]    acc_q, acc_nx;
  logic [WIDTH-1:0] hi_q, hi_nx, lo_q, lo_nx;

  // Result datapath from latched operands; even opcodes are the signed variants.
  logic                    is_signed;
  logic [DW-1:0]           a_ext, b_ext, product, result;
  logic signed [WIDTH:0]   da, db, db_safe, dq, dr;
  logic                    wr_en;
  logic                    unused_div_msbs;

  always_comb begin
    is_signed = ~op_q[0];
    a_ext     = {{WIDTH{is_signed & a_q[WIDTH-1]}}, a_q};
    b_ext     = {{WIDTH{is_signed & b_q[WIDTH-1]}}, b_q};
    product   = a_ext * b_ext;
    // One extra bit keeps most-negative / -1 representable, so no special case.
    da        = {is_signed & a_q[WIDTH-1], a_q};
    db        = {is_signed & b_q[WIDTH-1], b_q};
    db_safe   = (b_q == '0) ? (WIDTH+1)'(1) : db;
    dq        = da / db_safe;
    dr        = da % db_safe;
    unused_div_msbs = dq[WIDTH] ^ dr[WIDTH];
    wr_en     = !(((op_q == OP_DIV) || (op_q == OP_DIVU)) && (b_q == '0));
    case (op_q)
      OP_MULT, OP_MULTU: result = product;
      OP_DIV, OP_DIVU:   result = {dr[WIDTH-1:0], dq[WIDTH-1:0]};
      OP_MADD, OP_MADDU: result = acc_q + product;
      OP_MSUB, OP_MSUBU: result = acc_q - product;
      default:           result = {hi_q, lo_q};
    endcase
  end

  // Next-state and register-update logic.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    a_nx     = a_q;
    b_nx     = b_q;
    op_nx    = op_q;
    acc_nx   = acc_q;
    hi_nx    = hi_q;
    lo_nx    = lo_q;
    case (state)
      IDLE: begin
        if (mdu.start && !mdu.flush) begin
          if (mdu.op <= OP_MSUBU) begin
            a_nx     = mdu.a;
            b_nx     = mdu.b;
            op_nx    = mdu.op;
            acc_nx   = {hi_q, lo_q};
            cnt_nx   = ((mdu.op == OP_DIV) || (mdu.op == OP_DIVU)) ?
                       CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_nx = RUN;
          end else if (mdu.op == OP_MTHI) begin
            hi_nx = mdu.a;
          end else if (mdu.op == OP_MTLO) begin
            lo_nx = mdu.a;
          end
        end
      end
      RUN: begin
        if (mdu.flush) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_W'(1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          if (wr_en) begin
            hi_nx = result[DW-1:WIDTH];
            lo_nx = result[WIDTH-1:0];
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      acc_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      a_q   <= a_nx;
      b_q   <= b_nx;
      op_q  <= op_nx;
      acc_q <= acc_nx;
      hi_q  <= hi_nx;
      lo_q  <= lo_nx;
    end
  end

  assign mdu.busy = (state == RUN);
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;

endmodule

// File: tb/tb_mdu_core.sv
// tb_mdu_core: scoreboard bench for two mdu_core configurations
// (32-bit 5/10 cycles and 16-bit 1/33 cycles).
module tb_mdu_core;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_core_if #(.WIDTH(32)) m0();
  mdu_core_if #(.WIDTH(16)) m1();

  mdu_core #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut0 (
    .clk(clk), .reset(reset), .mdu(m0.slave));
  mdu_core #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(33)) dut1 (
    .clk(clk), .reset(reset), .mdu(m1.slave));

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    int          id;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   checks   = 0;
  int   failures = 0;
  int   id_ctr   = 0;
  int   run0     = 0;
  int   run1     = 0;

  function automatic void chk(string name, int id, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s op#%0d got=%h want=%h", name, id, got, want);
    end
  endfunction

  // Monitors: a completion is any busy 1->0 transition; pop and compare.
  always @(negedge clk) begin
    if (m0.busy) run0++;
    else if (run0 > 0) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut0_unexpected_done busy_cycles=%0d want=none", run0);
      end else begin
        e0 = q0.pop_front();
        chk("dut0_hi", e0.id, m0.hi, e0.hi);
        chk("dut0_lo", e0.id, m0.lo, e0.lo);
        chk("dut0_busy_cycles", e0.id, 32'(run0), 32'(e0.cyc));
      end
      run0 = 0;
    end
  end

  always @(negedge clk) begin
    if (m1.busy) run1++;
    else if (run1 > 0) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut1_unexpected_done busy_cycles=%0d want=none", run1);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_hi", e1.id, 32'(m1.hi), e1.hi);
        chk("dut1_lo", e1.id, 32'(m1.lo), e1.lo);
        chk("dut1_busy_cycles", e1.id, 32'(run1), 32'(e1.cyc));
      end
      run1 = 0;
    end
  end

  task automatic push(input int inst, input logic [31:0] hi, input logic [31:0] lo, input int cyc);
    exp_t e;
    e.hi = hi; e.lo = lo; e.cyc = cyc; e.id = id_ctr;
    id_ctr++;
    if (inst == 0) q0.push_back(e);
    else           q1.push_back(e);
  endtask

  // Called at a negedge; presents start for exactly one rising edge.
  task automatic go(input int inst, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (inst == 0) begin
      m0.start = 1'b1; m0.op = op; m0.a = a; m0.b = b;
    end else begin
      m1.start = 1'b1; m1.op = op; m1.a = a[15:0]; m1.b = b[15:0];
    end
    @(negedge clk);
    m0.start = 1'b0;
    m1.start = 1'b0;
  endtask

  task automatic wait_idle(input int inst);
    int n = 0;
    while (((inst == 0) ? m0.busy : m1.busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL wait_idle inst%0d busy_cycles=%0d want<100", inst, n);
    end
  endtask

  task automatic op_run(input int inst, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input int cyc);
    push(inst, hi, lo, cyc);
    go(inst, op, a, b);
    wait_idle(inst);
  endtask

  initial begin
    m0.start = 1'b0; m0.op = '0; m0.a = '0; m0.b = '0; m0.flush = 1'b0;
    m1.start = 1'b0; m1.op = '0; m1.a = '0; m1.b = '0; m1.flush = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy0", -1, 32'(m0.busy), 32'h0);
    chk("rst_hi0",   -1, m0.hi, 32'h0);
    chk("rst_lo0",   -1, m0.lo, 32'h0);
    chk("rst_busy1", -1, 32'(m1.busy), 32'h0);
    chk("rst_hi1",   -1, 32'(m1.hi), 32'h0);
    chk("rst_lo1",   -1, 32'(m1.lo), 32'h0);
    reset = 1'b0;

    // 32-bit instance, MULT_CYCLES=5, DIV_CYCLES=10
    op_run(0, 4'd0, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    op_run(0, 4'd1, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 5);
    op_run(0, 4'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    go(0, 4'd8, 32'h11, 32'h0);
    go(0, 4'd9, 32'h22, 32'h0);
    op_run(0, 4'd3, 32'h7, 32'h0, 32'h11, 32'h22, 10);
    go(0, 4'd8, 32'h0, 32'h0);
    go(0, 4'd9, 32'hFFFFFFFF, 32'h0);
    op_run(0, 4'd5, 32'h1, 32'h1, 32'h1, 32'h0, 5);
    op_run(0, 4'd6, 32'h1, 32'h2, 32'h0, 32'hFFFFFFFE, 5);
    op_run(0, 4'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10);
    op_run(0, 4'd4, 32'hFFFFFFFF, 32'h3, 32'h0, 32'h7FFFFFFD, 5);
    op_run(0, 4'd7, 32'h2, 32'h3, 32'h0, 32'h7FFFFFF7, 5);
    op_run(0, 4'd2, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 10);

    // flush on 3rd busy cycle: 3 busy cycles, hi/lo keep pre-op values
    push(0, 32'h1, 32'hFFFFFFFD, 3);
    go(0, 4'd0, 32'h5, 32'h5);
    @(negedge clk);
    @(negedge clk);
    m0.flush = 1'b1;
    @(negedge clk);
    m0.flush = 1'b0;
    wait_idle(0);

    // flush in IDLE suppresses an mthi
    m0.flush = 1'b1;
    go(0, 4'd8, 32'hDEAD, 32'h0);
    m0.flush = 1'b0;

    // start during busy is ignored; hi must not become DEAD
    push(0, 32'h0, 32'hC, 5);
    go(0, 4'd0, 32'h3, 32'h4);
    m0.start = 1'b1; m0.op = 4'd8; m0.a = 32'hDEAD;
    @(negedge clk);
    m0.start = 1'b0;
    wait_idle(0);

    // reset on 3rd busy cycle of a div, then start on first post-reset cycle
    push(0, 32'h0, 32'h0, 3);
    go(0, 4'd2, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    op_run(0, 4'd1, 32'h5, 32'h6, 32'h0, 32'd30, 5);

    // 16-bit instance, MULT_CYCLES=1, DIV_CYCLES=33
    op_run(1, 4'd0, 32'hFFFF, 32'h2, 32'hFFFF, 32'hFFFE, 1);
    op_run(1, 4'd1, 32'hFFFF, 32'h2, 32'h1, 32'hFFFE, 1);
    op_run(1, 4'd2, 32'hFFF9, 32'h2, 32'hFFFF, 32'hFFFD, 33);
    op_run(1, 4'd2, 32'h8000, 32'hFFFF, 32'h0, 32'h8000, 33);
    go(1, 4'd8, 32'h0, 32'h0);
    go(1, 4'd9, 32'hFFFF, 32'h0);
    op_run(1, 4'd5, 32'h1, 32'h1, 32'h1, 32'h0, 1);
    op_run(1, 4'd6, 32'h1, 32'h2, 32'h0, 32'hFFFE, 1);
    go(1, 4'd8, 32'h11, 32'h0);
    go(1, 4'd9, 32'h22, 32'h0);
    op_run(1, 4'd3, 32'h7, 32'h0, 32'h11, 32'h22, 33);

    // reset on 10th busy cycle of a div, then immediate start
    push(1, 32'h0, 32'h0, 10);
    go(1, 4'd2, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    op_run(1, 4'd0, 32'h3, 32'h4, 32'h0, 32'hC, 1);

    repeat (3) @(negedge clk);
    chk("q0_drained", -1, 32'(q0.size()), 32'h0);
    chk("q1_drained", -1, 32'(q1.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
